// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: mode encodings, channel state
// enumeration and the prescaler counter width helper.
package timer_pkg;

    // Channel counting modes, sampled from i_Mode on Start (2'b11 acts as SAT)
    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;

    // Per-channel FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } ch_state_e;

    // Bits needed to count 0..div-1, never less than one bit
    function automatic int cnt_width(input int div);
        int w;
        w = $clog2(div);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 and emits a registered one-cycle
// tick in the cycle following the terminal count. Never restarted by
// channel activity, so the tick phase depends only on reset release.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 2_000
) (
    input  logic clk_50M,
    input  logic i_Reset_n,
    output logic o_Tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = cnt_width(DIV);
    localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);

    // A divider below 2 cannot produce a distinct tick cycle
    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter and registered tick flag
    always_ff @(posedge clk_50M or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == LAST_C) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
            tick_r <= (cnt_r == LAST_C);
        end
    end

    assign o_Tick = tick_r;

endmodule

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/EXPIRED FSM that latches mode and limit on
// Start and steps its count on each enabled tick while running.
// Priority each cycle is Clear, then Start, then the tick step.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk_50M,
    input  logic             i_Reset_n,
    input  logic             i_Clear,
    input  logic             i_Start,
    input  logic             i_Enable,
    input  logic             i_Tick,
    input  logic [1:0]       i_Mode,
    input  logic [WIDTH-1:0] i_Limit,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_Busy,
    output logic             o_Done
);

    ch_state_e        state_r, state_nxt_s;
    logic [WIDTH-1:0] count_r, count_nxt_s;
    logic [WIDTH-1:0] limit_r, limit_nxt_s;
    logic [1:0]       mode_r,  mode_nxt_s;
    logic             done_r,  done_nxt_s;
    logic             busy_r,  busy_nxt_s;

    // State, latched configuration and registered outputs
    always_ff @(posedge clk_50M or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_r <= ST_IDLE;
            count_r <= {WIDTH{1'b0}};
            limit_r <= {WIDTH{1'b0}};
            mode_r  <= MODE_WRAP;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            limit_r <= limit_nxt_s;
            mode_r  <= mode_nxt_s;
            done_r  <= done_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Next state and count: clear beats start beats step
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        limit_nxt_s = limit_r;
        mode_nxt_s  = mode_r;
        done_nxt_s  = 1'b0;
        if (i_Clear) begin
            state_nxt_s = ST_IDLE;
            count_nxt_s = {WIDTH{1'b0}};
        end else if (i_Start) begin
            state_nxt_s = ST_RUN;
            mode_nxt_s  = i_Mode;
            limit_nxt_s = i_Limit;
            if (i_Mode == MODE_DOWN) begin
                count_nxt_s = i_Limit;
            end else begin
                count_nxt_s = {WIDTH{1'b0}};
            end
        end else if ((state_r == ST_RUN) && i_Enable && i_Tick) begin
            case (mode_r)
                MODE_WRAP: begin
                    if (count_r == limit_r) begin
                        count_nxt_s = {WIDTH{1'b0}};
                        done_nxt_s  = 1'b1;
                    end else begin
                        count_nxt_s = count_r + WIDTH'(1'b1);
                    end
                end
                MODE_DOWN: begin
                    if (count_r == {WIDTH{1'b0}}) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_EXPIRED;
                    end else begin
                        count_nxt_s = count_r - WIDTH'(1'b1);
                    end
                end
                default: begin
                    // SAT, and the unused 2'b11 encoding behaves the same
                    if (count_r == limit_r) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_EXPIRED;
                    end else begin
                        count_nxt_s = count_r + WIDTH'(1'b1);
                    end
                end
            endcase
        end else begin
            // IDLE, EXPIRED, paused or no tick: hold everything
            state_nxt_s = state_r;
        end
    end

    // Busy follows the state being entered so it drops with the final Done
    always_comb begin
        busy_nxt_s = 1'b0;
        if (state_nxt_s == ST_RUN) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    assign o_Count = count_r;
    assign o_Busy  = busy_r;
    assign o_Done  = done_r;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel tick timer: one shared prescaler feeding N_CH independent
// wrap / saturate / count-down channels.
module timer_bank
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 2_000,
    parameter int WIDTH   = 12,
    parameter int N_CH    = 4
) (
    input  logic                  clk_50M,
    input  logic                  i_Reset_n,
    input  logic [N_CH-1:0]       i_Clear,
    input  logic [N_CH-1:0]       i_Start,
    input  logic [N_CH-1:0]       i_Enable,
    input  logic [2*N_CH-1:0]     i_Mode,
    input  logic [WIDTH*N_CH-1:0] i_Limit,
    output logic [WIDTH*N_CH-1:0] o_Count,
    output logic [N_CH-1:0]       o_Busy,
    output logic [N_CH-1:0]       o_Done,
    output logic                  o_Tick
);

    logic tick_s;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk_50M   (clk_50M),
        .i_Reset_n (i_Reset_n),
        .o_Tick    (tick_s)
    );

    assign o_Tick = tick_s;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            timer_channel #(
                .WIDTH (WIDTH)
            ) u_ch (
                .clk_50M   (clk_50M),
                .i_Reset_n (i_Reset_n),
                .i_Clear   (i_Clear[k]),
                .i_Start   (i_Start[k]),
                .i_Enable  (i_Enable[k]),
                .i_Tick    (tick_s),
                .i_Mode    (i_Mode[2*k +: 2]),
                .i_Limit   (i_Limit[WIDTH*k +: WIDTH]),
                .o_Count   (o_Count[WIDTH*k +: WIDTH]),
                .o_Busy    (o_Busy[k]),
                .o_Done    (o_Done[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with a 10-cycle tick divider.
module tb_timer_bank;
    import timer_pkg::*;

    localparam int WIDTH = 12;
    localparam int N_CH  = 4;
    localparam int DIV   = 10;

    logic                  clk_50M;
    logic                  i_Reset_n;
    logic [N_CH-1:0]       i_Clear;
    logic [N_CH-1:0]       i_Start;
    logic [N_CH-1:0]       i_Enable;
    logic [2*N_CH-1:0]     i_Mode;
    logic [WIDTH*N_CH-1:0] i_Limit;
    logic [WIDTH*N_CH-1:0] o_Count;
    logic [N_CH-1:0]       o_Busy;
    logic [N_CH-1:0]       o_Done;
    logic                  o_Tick;

    int total = 0;
    int bad   = 0;

    timer_bank #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .WIDTH   (WIDTH),
        .N_CH    (N_CH)
    ) dut (
        .clk_50M   (clk_50M),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (i_Clear),
        .i_Start   (i_Start),
        .i_Enable  (i_Enable),
        .i_Mode    (i_Mode),
        .i_Limit   (i_Limit),
        .o_Count   (o_Count),
        .o_Busy    (o_Busy),
        .o_Done    (o_Done),
        .o_Tick    (o_Tick)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int k);
        return 32'(o_Count[WIDTH*k +: WIDTH]);
    endfunction

    // Advance to the next negedge at which o_Tick is high (bounded)
    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3*DIV && !seen; i++) begin
            @(negedge clk_50M);
            if (o_Tick === 1'b1) seen = 1'b1;
        end
        chk("tick_wait", 32'(seen), 32'd1);
    endtask

    // Wait for a tick, then sample just after the edge that applies the step
    task automatic step();
        wait_tick();
        @(negedge clk_50M);
    endtask

    task automatic start_ch(input int k, input logic [1:0] mode, input logic [WIDTH-1:0] lim);
        i_Mode[2*k +: 2]        = mode;
        i_Limit[WIDTH*k +: WIDTH] = lim;
        i_Start[k]              = 1'b1;
        @(negedge clk_50M);
        i_Start[k]              = 1'b0;
    endtask

    initial begin
        i_Reset_n = 1'b0;
        i_Clear   = '0;
        i_Start   = '0;
        i_Enable  = '0;
        i_Mode    = '0;
        i_Limit   = '0;
        repeat (3) @(negedge clk_50M);
        chk("rst_count", 32'(o_Count == '0), 32'd1);
        chk("rst_busy",  32'(o_Busy), 32'd0);
        chk("rst_done",  32'(o_Done), 32'd0);
        chk("rst_tick",  32'(o_Tick), 32'd0);
        i_Reset_n = 1'b1;

        // Tick at cycles 10, 20, 30 after release
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_50M);
            chk($sformatf("tick_c%0d", k), 32'(o_Tick), 32'((k % DIV) == 0));
        end
        chk("idle_count", 32'(o_Count == '0), 32'd1);
        chk("idle_busy",  32'(o_Busy), 32'd0);
        chk("idle_done",  32'(o_Done), 32'd0);

        @(negedge clk_50M);
        i_Enable = 4'b1111;

        // Ch0 WRAP limit 3: 0,1,2,3,0
        start_ch(0, MODE_WRAP, 12'd3);
        chk("w_busy0", 32'(o_Busy[0]), 32'd1);
        chk("w_cnt0",  cnt(0), 32'd0);
        for (int s = 1; s <= 4; s++) begin
            step();
            chk($sformatf("w_cnt_s%0d", s),  cnt(0), 32'(s % 4));
            chk($sformatf("w_done_s%0d", s), 32'(o_Done[0]), 32'(s == 4));
            chk($sformatf("w_busy_s%0d", s), 32'(o_Busy[0]), 32'd1);
        end
        @(negedge clk_50M);
        chk("w_done_one_cycle", 32'(o_Done[0]), 32'd0);

        // Ch1 SAT limit 5: done on the 6th step
        start_ch(1, MODE_SAT, 12'd5);
        chk("s_busy0", 32'(o_Busy[1]), 32'd1);
        for (int s = 1; s <= 6; s++) begin
            step();
            chk($sformatf("s_cnt_s%0d", s),  cnt(1), 32'((s < 5) ? s : 5));
            chk($sformatf("s_done_s%0d", s), 32'(o_Done[1]), 32'(s == 6));
            chk($sformatf("s_busy_s%0d", s), 32'(o_Busy[1]), 32'(s != 6));
        end
        step();
        chk("s_hold_cnt",  cnt(1), 32'd5);
        chk("s_hold_done", 32'(o_Done[1]), 32'd0);
        chk("s_hold_busy", 32'(o_Busy[1]), 32'd0);

        // Ch2 DOWN limit 4 with two lost ticks
        start_ch(2, MODE_DOWN, 12'd4);
        chk("d_cnt0", cnt(2), 32'd4);
        step(); chk("d_cnt_s1", cnt(2), 32'd3);
        step(); chk("d_cnt_s2", cnt(2), 32'd2);
        i_Enable[2] = 1'b0;
        step(); chk("d_pause1", cnt(2), 32'd2);
        step(); chk("d_pause2", cnt(2), 32'd2);
        chk("d_pause_busy", 32'(o_Busy[2]), 32'd1);
        i_Enable[2] = 1'b1;
        step(); chk("d_cnt_s3", cnt(2), 32'd1);
        step(); chk("d_cnt_s4", cnt(2), 32'd0);
        chk("d_done_early", 32'(o_Done[2]), 32'd0);
        step();
        chk("d_cnt_end",  cnt(2), 32'd0);
        chk("d_done_end", 32'(o_Done[2]), 32'd1);
        chk("d_busy_end", 32'(o_Busy[2]), 32'd0);
        chk("d_state",    32'(dut.g_ch[2].u_ch.state_r), 32'(ST_EXPIRED));

        // Ch3 running, then Clear+Start+tick; ch0 Start+tick; ch1 SAT limit 0
        start_ch(3, MODE_WRAP, 12'd7);
        step(); chk("c3_cnt1", cnt(3), 32'd1);
        wait_tick();
        i_Clear[3] = 1'b1;
        i_Start    = 4'b1011;
        i_Mode[1:0]   = MODE_WRAP; i_Limit[11:0]  = 12'd3;
        i_Mode[3:2]   = MODE_SAT;  i_Limit[23:12] = 12'd0;
        i_Mode[7:6]   = MODE_WRAP; i_Limit[47:36] = 12'd7;
        @(negedge clk_50M);
        i_Clear = '0;
        i_Start = '0;
        chk("cs_cnt3",   cnt(3), 32'd0);
        chk("cs_busy3",  32'(o_Busy[3]), 32'd0);
        chk("cs_done3",  32'(o_Done[3]), 32'd0);
        chk("cs_state3", 32'(dut.g_ch[3].u_ch.state_r), 32'(ST_IDLE));
        chk("rs_cnt0",   cnt(0), 32'd0);
        chk("rs_done0",  32'(o_Done[0]), 32'd0);
        chk("rs_busy0",  32'(o_Busy[0]), 32'd1);
        chk("z_busy1",   32'(o_Busy[1]), 32'd1);
        step();
        chk("rs_cnt0_s1", cnt(0), 32'd1);
        chk("z_done1",    32'(o_Done[1]), 32'd1);
        chk("z_cnt1",     cnt(1), 32'd0);
        chk("z_busy1_end", 32'(o_Busy[1]), 32'd0);
        chk("cs_cnt3_s1", cnt(3), 32'd0);

        // Async reset between edges
        step();
        chk("pre_rst_busy0", 32'(o_Busy[0]), 32'd1);
        chk("pre_rst_cnt0",  cnt(0), 32'd2);
        @(posedge clk_50M);
        #3;
        i_Reset_n = 1'b0;
        #1;
        chk("ar_count", 32'(o_Count == '0), 32'd1);
        chk("ar_busy",  32'(o_Busy), 32'd0);
        chk("ar_done",  32'(o_Done), 32'd0);
        chk("ar_tick",  32'(o_Tick), 32'd0);
        @(negedge clk_50M);
        i_Reset_n = 1'b1;
        for (int k = 1; k <= DIV; k++) begin
            @(negedge clk_50M);
            chk($sformatf("ar_tick_c%0d", k), 32'(o_Tick), 32'(k == DIV));
        end
        chk("ar_busy_after", 32'(o_Busy), 32'd0);
        chk("ar_state0", 32'(dut.g_ch[0].u_ch.state_r), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
